pipe_hazard_ctl: RTL

- Central stall/flush scheduler for the 5-stage pipelined CPU; sits beside the ID stage.
- Decides per cycle whether PC/IF-ID advance, whether a bubble enters ID/EX, whether IF/ID is flushed after a taken branch or jump, and whether the whole pipe freezes on a data-memory wait.
- Also owns occupancy of a shared multi-cycle multiply/divide unit: issues its start and stalls dependent or conflicting instructions until it finishes.

---
 rtl/pipe_hazard_ctl_pkg.sv | 17 +
 rtl/pipe_hazard_ctl_if.sv | 34 +++
 rtl/pipe_hazard_ctl_sat_cnt.sv | 22 ++
 rtl/pipe_hazard_ctl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_ctl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        MEMW = 1'b1
    } ctl_state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam int MD_CNT_W   = 8;
    localparam int WAIT_CNT_W = 10;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the pipeline datapath (master) and the hazard scheduler (slave).
interface pipe_hazard_ctl_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic [4:0] ern;
    logic       ewreg;
    logic       em2reg;
    logic [1:0] pcsource;
    logic       d_md;
    logic       d_mfhilo;
    logic       mem_req;
    logic       mem_ready;
    logic       wpcir;
    logic       d_bubble;
    logic       f_flush;
    logic       pipe_en;
    logic       md_start;
    logic       md_busy;
    logic       mem_err;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, ern, ewreg, em2reg, pcsource,
               d_md, d_mfhilo, mem_req, mem_ready,
        input  wpcir, d_bubble, f_flush, pipe_en, md_start, md_busy, mem_err
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, ern, ewreg, em2reg, pcsource,
               d_md, d_mfhilo, mem_req, mem_ready,
        output wpcir, d_bubble, f_flush, pipe_en, md_start, md_busy, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctl_sat_cnt.sv
// Saturating event counter: holds at all-ones, clears on reset or clr.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush/freeze scheduler for the 5-stage pipe, plus mul/div occupancy tracking.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int MD_CYCLES   = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    pipe_hazard_ctl_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    lu_stall_cnt,
    output logic [CNT_W-1:0]    md_stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
    output logic [CNT_W-1:0]    freeze_cnt
`endif
);

    if (MD_CYCLES < 2 || MD_CYCLES > 255 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 1023 || CNT_W < 1)
    begin : g_param_check
        $error("pipe_hazard_ctl: parameter out of range");
    end

    ctl_state_e              state_reg;
    logic [MD_CNT_W-1:0]     md_cnt_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;

    logic tmo;
    logic load_use;
    logic md_haz;
    logic p1_freeze;
    logic p2_lu;
    logic p3_md;
    logic p4_flush;
    logic stall;
    logic md_start_int;

    always_comb begin
        tmo       = (state_reg == MEMW) && (wait_cnt_reg == WAIT_CNT_W'(MEM_TIMEOUT - 1));
        load_use  = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
                    ((bus.d_use_rs && (bus.ern == bus.d_rs)) ||
                     (bus.d_use_rt && (bus.ern == bus.d_rt)));
        md_haz    = (bus.d_md || bus.d_mfhilo) && (md_cnt_reg != '0);
        p1_freeze = bus.mem_req && !bus.mem_ready && !tmo;
        p2_lu     = !p1_freeze && load_use;
        p3_md     = !p1_freeze && !load_use && md_haz;
        stall     = p1_freeze || p2_lu || p3_md;
        // A stalled branch is simply re-resolved next cycle, so flush only when nothing stalls.
        p4_flush  = !stall && (bus.pcsource != PCSRC_SEQ);
        md_start_int = bus.d_md && !stall;
    end

    assign bus.pipe_en  = !p1_freeze;
    assign bus.wpcir    = !stall;
    assign bus.d_bubble = p2_lu || p3_md;
    assign bus.f_flush  = p4_flush;
    assign bus.md_start = md_start_int;
    assign bus.md_busy  = (md_cnt_reg != '0);
    assign bus.mem_err  = tmo;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= RUN;
            md_cnt_reg   <= '0;
            wait_cnt_reg <= '0;
        end else begin
            if (md_start_int) begin
                md_cnt_reg <= MD_CNT_W'(MD_CYCLES);
            end else if (md_cnt_reg != '0) begin
                md_cnt_reg <= md_cnt_reg - MD_CNT_W'(1);
            end

            // wait_cnt counts every freeze cycle of the episode, including the entry cycle.
            unique case (state_reg)
                RUN: begin
                    if (p1_freeze) begin
                        state_reg    <= MEMW;
                        wait_cnt_reg <= WAIT_CNT_W'(1);
                    end else begin
                        wait_cnt_reg <= '0;
                    end
                end
                MEMW: begin
                    if (bus.mem_ready || !bus.mem_req || tmo) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [3:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [4];

    assign perf_inc = {p1_freeze, p4_flush, p3_md, p2_lu};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_perf
        pipe_sat_cnt #(.W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (perf_inc[gi]),
            .clr   (1'b0),
            .cnt   (perf_cnt[gi])
        );
    end

    assign lu_stall_cnt = perf_cnt[0];
    assign md_stall_cnt = perf_cnt[1];
    assign flush_cnt    = perf_cnt[2];
    assign freeze_cnt   = perf_cnt[3];
`endif

endmodule
